// File: rtl/fir_out_requantizer.sv
// Two-stage requantizer from the Q12.10 FIR output to Q4.5: S1 rounds, S2 saturates, with a valid/ready handshake.
// Define FIR_REQ_CONV_ROUND_EN for round-half-to-even; the default build rounds half-up.
module fir_out_requantizer #(
    parameter int WII = 12,
    parameter int WFI = 10,
    parameter int WIO = 4,
    parameter int WFO = 5
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [WII+WFI-1:0]   Filt_In,
    input  logic                 ovf_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIO+WFO-1:0]   Req_Out,
    output logic                 out_sat,
    output logic                 out_ovf,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 cnt_clr,
    output logic [7:0]           sat_count
);

    localparam int WI = WII + WFI;
    localparam int SH = WFI - WFO;
    localparam int WE = WI + 1;
    localparam int WR = WE - SH;
    localparam int WO = WIO + WFO;
    localparam logic [WE-1:0] RND_HALF = WE'(2 ** (SH - 1));

    logic              en1, en2;
    logic [WE-1:0]     ext, rnd, sum;
    logic [WR-1:0]     rounded;
    logic [WR-WO:0]    upper;
    logic              clip;
    logic [WO-1:0]     sat_val;

    logic              s1_valid_q, s1_valid_d;
    logic [WR-1:0]     s1_val_q, s1_val_d;
    logic              s1_ovf_q, s1_ovf_d;
    logic              s2_valid_q, s2_valid_d;
    logic [WO-1:0]     req_q, req_d;
    logic              sat_q, sat_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        cnt_q, cnt_d;

    always_comb begin
        en2 = ~s2_valid_q | out_ready;
        en1 = ~s1_valid_q | en2;

        ext = {Filt_In[WI-1], Filt_In};
`ifdef FIR_REQ_CONV_ROUND_EN
        rnd = RND_HALF - WE'(1) + WE'(Filt_In[SH]);
`else
        rnd = RND_HALF;
`endif
        sum     = ext + rnd;
        rounded = WR'($signed(sum) >>> SH);

        // The value fits the output iff every bit above the output sign bit copies it.
        upper   = s1_val_q[WR-1:WO-1];
        clip    = ~((&upper) | ~(|upper));
        sat_val = s1_val_q[WR-1] ? {1'b1, {(WO-1){1'b0}}} : {1'b0, {(WO-1){1'b1}}};

        s1_valid_d = s1_valid_q;
        s1_val_d   = s1_val_q;
        s1_ovf_d   = s1_ovf_q;
        s2_valid_d = s2_valid_q;
        req_d      = req_q;
        sat_d      = sat_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;

        if (en1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_val_d = rounded;
                s1_ovf_d = ovf_in;
            end
        end

        if (en2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                req_d = clip ? sat_val : s1_val_q[WO-1:0];
                sat_d = clip;
                ovf_d = s1_ovf_q | clip;
            end
        end

        if (cnt_clr) begin
            cnt_d = 8'd0;
        end else if (s2_valid_q && out_ready && sat_q && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            req_q      <= '0;
            sat_q      <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            req_q      <= req_d;
            sat_q      <= sat_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
        end
    end

    // NOTE: S1 payload is left out of reset; it is only observed while s1_valid_q is set.
    always_ff @(posedge CLK) begin
        s1_val_q <= s1_val_d;
        s1_ovf_q <= s1_ovf_d;
    end

    assign in_ready  = en1;
    assign out_valid = s2_valid_q;
    assign Req_Out   = req_q;
    assign out_sat   = sat_q;
    assign out_ovf   = ovf_q;
    assign sat_count = cnt_q;

endmodule

// File: tb/tb_fir_out_requantizer.sv
// Scoreboard bench for fir_out_requantizer at default parameters; follows FIR_REQ_CONV_ROUND_EN for rounding.
module tb_fir_out_requantizer;

    typedef struct packed {
        logic [8:0] req;
        logic       sat;
        logic       ovf;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [21:0] Filt_In = '0;
    logic        ovf_in = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [8:0]  Req_Out;
    logic        out_sat;
    logic        out_ovf;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [7:0]  sat_count;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    fir_out_requantizer dut (
        .CLK(CLK), .RESET(RESET), .Filt_In(Filt_In), .ovf_in(ovf_in),
        .in_valid(in_valid), .in_ready(in_ready), .Req_Out(Req_Out),
        .out_sat(out_sat), .out_ovf(out_ovf), .out_valid(out_valid),
        .out_ready(out_ready), .cnt_clr(cnt_clr), .sat_count(sat_count)
    );

    always #5 CLK = ~CLK;

    // Reference: floor-divide by 32, round by remainder, clamp to -256..255.
    function automatic exp_t model(input logic [21:0] x, input logic ovf);
        longint v, q, r;
        exp_t   e;
        v = longint'($signed(x));
        q = v >>> 5;
        r = v - q * 32;
`ifdef FIR_REQ_CONV_ROUND_EN
        if (r > 16 || (r == 16 && (q % 2 != 0))) q = q + 1;
`else
        if (r >= 16) q = q + 1;
`endif
        e.sat = 1'b0;
        if (q > 255) begin
            q = 255;
            e.sat = 1'b1;
        end else if (q < -256) begin
            q = -256;
            e.sat = 1'b1;
        end
        e.req = q[8:0];
        e.ovf = ovf | e.sat;
        return e;
    endfunction

    // Output monitor: every transfer is compared against the oldest expected sample.
    always @(negedge CLK) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            exp_t e;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got req=%h sat=%b ovf=%b, none expected",
                         Req_Out, out_sat, out_ovf);
            end else begin
                e = sb_q.pop_front();
                if ({Req_Out, out_sat, out_ovf} !== e) begin
                    errors++;
                    $display("FAIL output got req=%h sat=%b ovf=%b want req=%h sat=%b ovf=%b",
                             Req_Out, out_sat, out_ovf, e.req, e.sat, e.ovf);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input int x, input logic ovf);
        Filt_In  = 22'(x);
        ovf_in   = ovf;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (in_ready) begin
                sb_q.push_back(model(Filt_In, ovf_in));
                tick();
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        in_valid = 1'b0;
        checks++;
        errors++;
        $display("FAIL send_timeout value=%0d not accepted", x);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick();
        repeat (2) tick();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d pending want 0", sb_q.size());
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (2) tick();
        @(negedge CLK);
        checks++;
        if ({out_valid, Req_Out, out_sat, out_ovf, sat_count} !== 20'd0) begin
            errors++;
            $display("FAIL reset_state got valid=%b req=%h sat=%b ovf=%b cnt=%0d want all 0",
                     out_valid, Req_Out, out_sat, out_ovf, sat_count);
        end
        tick();
        RESET = 1'b0;
        tick();
        @(negedge CLK);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        tick();
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        send(32'h600, 1'b0);
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early got out_valid=%b want 0", out_valid);
        end
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b1 || Req_Out !== 9'h030 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL latency_1p5 got valid=%b req=%h sat=%b want valid=1 req=030 sat=0",
                     out_valid, Req_Out, out_sat);
        end
        tick();
        drain();
    endtask

    task automatic test_rounding();
        int vals[10] = '{16, 48, -16, -48, 15, 17, 47, 80, -1, 0};
        out_ready = 1'b1;
        foreach (vals[i]) send(vals[i], 1'b0);
        drain();
    endtask

    task automatic test_saturation();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        out_ready = 1'b1;
        send(102400, 1'b0);
        send(-102400, 1'b0);
        drain();
        checks++;
        if (sat_count !== 8'd2) begin
            errors++;
            $display("FAIL sat_count_two got %0d want 2", sat_count);
        end
        send(100, 1'b1);
        send(8160, 1'b0);
        send(8176, 1'b0);
        send(-8192, 1'b0);
        send(-8209, 1'b0);
        drain();
        checks++;
        if (sat_count !== 8'd4) begin
            errors++;
            $display("FAIL sat_count_edges got %0d want 4", sat_count);
        end
    endtask

    task automatic test_back_to_back();
        int vals[4] = '{32'h600, -1000, 5000, 102400};
        int idx = 0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 20 && idx < 4; cyc++) begin
            if (cyc == 3) out_ready = 1'b1;
            Filt_In  = 22'(vals[idx]);
            ovf_in   = 1'b0;
            in_valid = 1'b1;
            @(negedge CLK);
            if (cyc == 2) begin
                checks++;
                if (in_ready !== 1'b0 || idx != 2) begin
                    errors++;
                    $display("FAIL b2b_backpressure got in_ready=%b accepted=%0d want 0 and 2",
                             in_ready, idx);
                end
            end
            if (in_ready) begin
                sb_q.push_back(model(Filt_In, ovf_in));
                idx++;
            end
            tick();
        end
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_sat_count_limit();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        out_ready = 1'b1;
        repeat (255) send(102400, 1'b0);
        drain();
        checks++;
        if (sat_count !== 8'd255) begin
            errors++;
            $display("FAIL sat_count_255 got %0d want 255", sat_count);
        end
        send(-102400, 1'b0);
        drain();
        checks++;
        if (sat_count !== 8'd255) begin
            errors++;
            $display("FAIL sat_count_stick got %0d want 255", sat_count);
        end
        out_ready = 1'b0;
        send(102400, 1'b0);
        for (int i = 0; i < 10 && out_valid !== 1'b1; i++) tick();
        out_ready = 1'b1;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        @(negedge CLK);
        checks++;
        if (sat_count !== 8'd0) begin
            errors++;
            $display("FAIL sat_count_clr_priority got %0d want 0", sat_count);
        end
        tick();
        drain();
    endtask

    task automatic test_reset_midop();
        out_ready = 1'b0;
        send(1000, 1'b0);
        send(2000, 1'b1);
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midop_full got out_valid=%b in_ready=%b want 1 and 0",
                     out_valid, in_ready);
        end
        tick();
        RESET = 1'b1;
        sb_q.delete();
        tick();
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b0 || sat_count !== 8'd0) begin
            errors++;
            $display("FAIL midop_reset got out_valid=%b cnt=%0d want 0 and 0", out_valid, sat_count);
        end
        tick();
        RESET = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_random();
        int v;
        for (int cyc = 0; cyc < 300; cyc++) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            ovf_in    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) != 0) v = int'($urandom_range(0, 32767)) - 16384;
            else v = int'($urandom());
            Filt_In = 22'(v);
            @(negedge CLK);
            if (in_valid && in_ready) sb_q.push_back(model(Filt_In, ovf_in));
            tick();
        end
        in_valid = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_rounding();
        test_saturation();
        test_back_to_back();
        test_sat_count_limit();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
